rr_arbiter8: RTL and testbench

- Round-robin arbiter sharing one resource between 8 requesters, e.g. a bus port or a register-file write port.
- Winner index is 3-bit; the one-hot grant vector is that index decoded 3-to-8.
- Sits between requesting units and the shared resource.
- Controls the resource select lines and tracks ownership until release.

---
 rtl/rr_arbiter8_if.sv | 19 +
 rtl/rr_arbiter8.sv | 100 ++++++++++
 tb/tb_rr_arbiter8.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the requesting units and the round-robin arbiter.
interface rr_arbiter8_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  modport master (
    output req, done,
    input  grant, grant_idx, grant_valid, timeout
  );

  modport slave (
    input  req, done,
    output grant, grant_idx, grant_valid, timeout
  );
endinterface

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with IDLE -> GRANT -> GAP tenure cycle.
// Optional forced release after MAX_HOLD grant cycles when ARB_TIMEOUT_EN is defined.
module rr_arbiter8
`ifdef ARB_TIMEOUT_EN
  #(parameter int MAX_HOLD = 16)
`endif
(
  input logic         clk,
  input logic         rst_n,
  rr_arbiter8_if.slave bus
);

  localparam int N_REQ = 8;

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t     state;
  logic [2:0] ptr;
  logic [2:0] winner;
  logic [2:0] cand;
  logic       found;
  logic       release_now;
  logic       force_release;

  // First requester found scanning upward from ptr, wrapping through 7 back to 0.
  always_comb begin
    winner = ptr;
    cand   = ptr;
    found  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = ptr + 3'(i);
      if (!found && bus.req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign release_now = bus.done || !bus.req[bus.grant_idx];

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] hold_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= 8'd0;
    end else if (state == GRANT) begin
      hold_cnt <= hold_cnt + 8'd1;
    end else begin
      hold_cnt <= 8'd0;
    end
  end

  // A normal release in the final cycle wins, so the timeout pulse is suppressed.
  assign force_release = (state == GRANT) && (hold_cnt == HOLD_LAST) && !release_now;
  assign bus.timeout   = force_release;
`else
  assign force_release = 1'b0;
  assign bus.timeout   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      ptr             <= 3'd0;
      bus.grant       <= 8'h00;
      bus.grant_idx   <= 3'd0;
      bus.grant_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req) begin
            bus.grant_idx   <= winner;
            bus.grant       <= 8'h01 << winner;
            bus.grant_valid <= 1'b1;
            state           <= GRANT;
          end
        end
        GRANT: begin
          if (release_now || force_release) begin
            ptr             <= bus.grant_idx + 3'd1;
            bus.grant       <= 8'h00;
            bus.grant_idx   <= 3'd0;
            bus.grant_valid <= 1'b0;
            state           <= GAP;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8: reset, single requester, full rotation, withdrawal,
// asynchronous reset mid-grant and the hold-timeout behaviour (ARB_TIMEOUT_EN).
module tb_rr_arbiter8;

  logic clk;
  logic rst_n;
  int   testCount;
  int   failCount;

  rr_arbiter8_if bus();

`ifdef ARB_TIMEOUT_EN
  rr_arbiter8 #(.MAX_HOLD(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`else
  rr_arbiter8 dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Outputs packed as {grant, grant_valid, grant_idx, timeout, 3'b0} for one-shot comparison.
  function automatic logic [15:0] pack(input logic [7:0] g, input logic v, input logic [2:0] idx, input logic t);
    return {g, v, idx, t, 3'b000};
  endfunction

  function automatic logic [15:0] observed();
    return pack(bus.grant, bus.grant_valid, bus.grant_idx, bus.timeout);
  endfunction

  task automatic applyStimulus(input logic [7:0] reqVal, input logic doneVal);
    bus.req  = reqVal;
    bus.done = doneVal;
  endtask

  task automatic nextCycle();
    @(negedge clk);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst_n = 1'b0;
    applyStimulus(8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    testCount = 0;
    failCount = 0;
    rst_n = 1'b0;
    applyStimulus(8'h00, 1'b0);
    #3;
    checkOutput("reset_values", observed(), pack(8'h00, 1'b0, 3'd0, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      nextCycle();
      checkOutput($sformatf("idle_no_req_%0d", i), observed(), pack(8'h00, 1'b0, 3'd0, 1'b0));
    end

    // Single requester 0, released by done, then regranted after GAP and IDLE.
    applyStimulus(8'h01, 1'b0);
    nextCycle();
    checkOutput("single_grant", observed(), pack(8'h01, 1'b1, 3'd0, 1'b0));
    applyStimulus(8'h01, 1'b1);
    nextCycle();
    checkOutput("single_gap", observed(), pack(8'h00, 1'b0, 3'd0, 1'b0));
    applyStimulus(8'h01, 1'b0);
    nextCycle();
    checkOutput("single_idle", observed(), pack(8'h00, 1'b0, 3'd0, 1'b0));
    nextCycle();
    checkOutput("single_regrant", observed(), pack(8'h01, 1'b1, 3'd0, 1'b0));
    applyStimulus(8'h01, 1'b1);
    nextCycle();
    applyStimulus(8'h00, 1'b1);
    nextCycle();
    applyStimulus(8'h00, 1'b0);
    nextCycle();
    checkOutput("done_in_idle_ignored", observed(), pack(8'h00, 1'b0, 3'd0, 1'b0));

    // Full rotation with all requesters active from ptr=0.
    pulseReset();
    applyStimulus(8'hFF, 1'b0);
    nextCycle();
    checkOutput("rot_first", observed(), pack(8'h01, 1'b1, 3'd0, 1'b0));
    nextCycle();
    checkOutput("rot_hold_no_preempt", observed(), pack(8'h01, 1'b1, 3'd0, 1'b0));
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(8'hFF, 1'b1);
      nextCycle();
      checkOutput($sformatf("rot_gap_%0d", k), observed(), pack(8'h00, 1'b0, 3'd0, 1'b0));
      applyStimulus(8'hFF, 1'b0);
      nextCycle();
      nextCycle();
      checkOutput($sformatf("rot_grant_%0d", k), observed(),
                  pack(8'h01 << (k % 8), 1'b1, 3'(k % 8), 1'b0));
    end

    // Owner 3 withdraws without done; ptr moves to 4 so requester 4 beats 3.
    pulseReset();
    applyStimulus(8'h08, 1'b0);
    nextCycle();
    checkOutput("withdraw_owner3", observed(), pack(8'h08, 1'b1, 3'd3, 1'b0));
    applyStimulus(8'h00, 1'b0);
    nextCycle();
    checkOutput("withdraw_gap", observed(), pack(8'h00, 1'b0, 3'd0, 1'b0));
    applyStimulus(8'h18, 1'b0);
    nextCycle();
    checkOutput("withdraw_idle", observed(), pack(8'h00, 1'b0, 3'd0, 1'b0));
    nextCycle();
    checkOutput("withdraw_next4", observed(), pack(8'h10, 1'b1, 3'd4, 1'b0));

    // Asynchronous reset between clock edges while requester 4 owns.
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_mid_grant", observed(), pack(8'h00, 1'b0, 3'd0, 1'b0));
    @(negedge clk);
    applyStimulus(8'h80, 1'b0);
    rst_n = 1'b1;
    nextCycle();
    checkOutput("after_reset_req7", observed(), pack(8'h80, 1'b1, 3'd7, 1'b0));

    // Requester 2 holds without done.
    pulseReset();
    applyStimulus(8'h04, 1'b0);
`ifdef ARB_TIMEOUT_EN
    for (int c = 1; c <= 4; c++) begin
      nextCycle();
      checkOutput($sformatf("hold_cycle_%0d", c), observed(),
                  pack(8'h04, 1'b1, 3'd2, (c == 4) ? 1'b1 : 1'b0));
    end
    nextCycle();
    checkOutput("timeout_gap", observed(), pack(8'h00, 1'b0, 3'd0, 1'b0));
    nextCycle();
    checkOutput("timeout_idle", observed(), pack(8'h00, 1'b0, 3'd0, 1'b0));
    nextCycle();
    checkOutput("timeout_regrant", observed(), pack(8'h04, 1'b1, 3'd2, 1'b0));
`else
    for (int c = 1; c <= 55; c++) begin
      nextCycle();
      checkOutput($sformatf("hold_cycle_%0d", c), observed(), pack(8'h04, 1'b1, 3'd2, 1'b0));
    end
`endif

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
